// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state encoding and byte-lane constants for the boot controller
package boot_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT,
    ST_RUN,
    ST_DONE,
    ST_ERROR
  } boot_state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - assembles little-endian 32-bit words from a byte stream
module byte_packer
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_data,
  output logic [LANE_W-1:0] lane,
  output logic [31:0]       word
);

  logic [23:0] low_q;

  // Lane counter plus the three low bytes of the word in progress; the top
  // byte is taken straight from the input on the lane-3 transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane  <= '0;
      low_q <= '0;
    end else if (clear) begin
      lane  <= '0;
      low_q <= '0;
    end else if (accept) begin
      case (lane)
        2'd0:    low_q[7:0]   <= byte_data;
        2'd1:    low_q[15:8]  <= byte_data;
        2'd2:    low_q[23:16] <= byte_data;
        default: ;
      endcase
      lane <= lane + 1'b1;
    end
  end

  assign word = {byte_data, low_q};

endmodule

// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - loads a program into instruction memory, then runs the CPU for a cycle budget
module imem_boot_ctrl
  import boot_pkg::*;
#(
  parameter int IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] cycle_budget,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        cpu_clk_en,
  output logic [15:0] cycles_run,
  output logic        busy,
  output logic        done,
  output logic        error
);

  boot_state_t       state;
  logic [31:0]       word_addr;
  logic [15:0]       budget_q;
  logic [LANE_W-1:0] lane;
  logic [31:0]       packed_word;
  logic              accept;
  logic              start_ok;
  logic              overflow;
  logic              lane_full;

  assign accept    = byte_valid && byte_ready;
  assign start_ok  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign overflow  = (word_addr == 32'(IMEM_BYTES));
  assign lane_full = (lane == LANE_W'(LANES - 1));

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .accept    (accept),
    .byte_data (byte_data),
    .lane      (lane),
    .word      (packed_word)
  );

  // Sequencer: load words, commit the last one, run the CPU, then park.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      word_addr  <= '0;
      budget_q   <= '0;
      cycles_run <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state      <= ST_LOAD;
            word_addr  <= '0;
            cycles_run <= '0;
            budget_q   <= cycle_budget;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (overflow) begin
              state <= ST_ERROR;
            end else if (lane_full) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_addr;
              imem_wdata <= packed_word;
              word_addr  <= word_addr + 32'd4;
              if (byte_last) state <= ST_COMMIT;
            end else if (byte_last) begin
              state <= ST_ERROR;
            end
          end
        end
        ST_COMMIT: begin
          state <= (budget_q == 16'd0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          cycles_run <= cycles_run + 16'd1;
          if ((cycles_run + 16'd1) == budget_q) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status and CPU controls are pure decodes of the state register.
  assign byte_ready = (state == ST_LOAD);
  assign cpu_clk_en = (state == ST_RUN);
  assign cpu_reset  = (state == ST_IDLE) || (state == ST_LOAD) ||
                      (state == ST_COMMIT) || (state == ST_ERROR);
  assign busy       = (state == ST_LOAD) || (state == ST_COMMIT) || (state == ST_RUN);
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_ERROR);

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb/tb_imem_boot_ctrl.sv - self-checking bench for imem_boot_ctrl
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cycle_budget = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_last = 1'b0;

  logic        byte_ready, imem_we, cpu_reset, cpu_clk_en, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] cycles_run;

  logic        s_byte_ready, s_imem_we, s_cpu_reset, s_cpu_clk_en, s_busy, s_done, s_error;
  logic [31:0] s_imem_addr, s_imem_wdata;
  logic [15:0] s_cycles_run;

  imem_boot_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cycle_budget(cycle_budget),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .cpu_clk_en(cpu_clk_en),
    .cycles_run(cycles_run), .busy(busy), .done(done), .error(error)
  );

  imem_boot_ctrl #(.IMEM_BYTES(8)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .cycle_budget(cycle_budget),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(s_byte_ready), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
    .imem_wdata(s_imem_wdata), .cpu_reset(s_cpu_reset), .cpu_clk_en(s_cpu_clk_en),
    .cycles_run(s_cycles_run), .busy(s_busy), .done(s_done), .error(s_error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  prog [16];
  logic [63:0] wr_main[$];
  logic [63:0] wr_small[$];
  int          en_main = 0;
  int          en_small = 0;

  always @(negedge clk) begin
    if (imem_we)      wr_main.push_back({imem_addr, imem_wdata});
    if (s_imem_we)    wr_small.push_back({s_imem_addr, s_imem_wdata});
    if (cpu_clk_en)   en_main++;
    if (s_cpu_clk_en) en_small++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".byte_ready"}, 32'(byte_ready), 0);
    check({tag, ".imem_we"},    32'(imem_we),    0);
    check({tag, ".imem_addr"},  imem_addr,       0);
    check({tag, ".imem_wdata"}, imem_wdata,      0);
    check({tag, ".cpu_reset"},  32'(cpu_reset),  1);
    check({tag, ".cpu_clk_en"}, 32'(cpu_clk_en), 0);
    check({tag, ".cycles_run"}, 32'(cycles_run), 0);
    check({tag, ".busy"},       32'(busy),       0);
    check({tag, ".done"},       32'(done),       0);
    check({tag, ".error"},      32'(error),      0);
  endtask

  // Reference: walk the byte list; a byte at or past memory end, or a last
  // flag that does not close a word, ends the load in error.
  task automatic model(input int n, input int last_idx, input int size,
                       output int nwr, output bit err);
    nwr = 0;
    err = 0;
    for (int i = 0; i < n; i++) begin
      if ((i / 4) * 4 >= size) begin err = 1; return; end
      if (i % 4 == 3) nwr++;
      if (i == last_idx) begin err = (i % 4 != 3); return; end
    end
  endtask

  task automatic verify_one(input string tag, input int size, input int n, input int last_idx,
                            input int budget, input logic [63:0] wq[$], input int en_cnt,
                            input logic err_f, input logic done_f, input logic [15:0] cyc,
                            input logic rst_f, input logic busy_f, input logic rdy_f);
    int nwr;
    bit err;
    logic [31:0] w;
    model(n, last_idx, size, nwr, err);
    check({tag, ".writes"}, wq.size(), nwr);
    for (int k = 0; k < nwr && k < wq.size(); k++) begin
      w = {prog[4*k+3], prog[4*k+2], prog[4*k+1], prog[4*k]};
      check($sformatf("%s.addr%0d", tag, k), wq[k][63:32], 32'(4 * k));
      check($sformatf("%s.data%0d", tag, k), wq[k][31:0], w);
    end
    check({tag, ".error"},      32'(err_f),  32'(err));
    check({tag, ".done"},       32'(done_f), 32'(!err));
    check({tag, ".cycles_run"}, 32'(cyc),    err ? 0 : budget);
    check({tag, ".clk_en_cnt"}, en_cnt,      err ? 0 : budget);
    check({tag, ".cpu_reset"},  32'(rst_f),  32'(err));
    check({tag, ".busy"},       32'(busy_f), 0);
    check({tag, ".byte_ready"}, 32'(rdy_f),  0);
  endtask

  task automatic verify_both(input int n, input int last_idx, input int budget);
    verify_one("main", 1024, n, last_idx, budget, wr_main, en_main, error, done,
               cycles_run, cpu_reset, busy, byte_ready);
    verify_one("small", 8, n, last_idx, budget, wr_small, en_small, s_error, s_done,
               s_cycles_run, s_cpu_reset, s_busy, s_byte_ready);
  endtask

  // Starts a run, streams prog[0..n-1] honouring byte_ready, then waits for
  // the main instance to finish. abort_at>0 pulls reset in that RUN cycle.
  task automatic do_run(input int n, input int last_idx, input int budget,
                        input bit gaps, input bit poke, input int abort_at);
    int  i = 0;
    int  guard = 0;
    int  k = 0;
    bit  pend = 0;
    bit  seen = 0;
    bit  poked = 0;
    wr_main.delete();
    wr_small.delete();
    en_main = 0;
    en_small = 0;
    start = 1'b1;
    cycle_budget = 16'(budget);
    @(negedge clk);
    start = 1'b0;
    while (guard < 300) begin
      if (pend) i++;
      pend = 0;
      if (byte_ready) seen = 1;
      if (i >= n || (seen && !byte_ready)) break;
      start      = poke && (i == 3);
      byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      byte_data  = prog[i];
      byte_last  = (i == last_idx);
      pend       = byte_valid && byte_ready;
      @(negedge clk);
      guard++;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    start      = 1'b0;
    check("drive_timeout", 32'(guard < 300), 1);
    guard = 0;
    while (!(done || error) && guard < 200) begin
      if (cpu_clk_en) k++;
      if (abort_at > 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        return;
      end
      if (poke && cpu_clk_en && !poked) begin start = 1'b1; poked = 1; end
      else start = 1'b0;
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check("run_timeout", 32'(guard < 200), 1);
    @(negedge clk);
  endtask

  task automatic load_fixed();
    logic [7:0] p [8];
    p = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    for (int j = 0; j < 8; j++) prog[j] = p[j];
  endtask

  task automatic load_random();
    for (int j = 0; j < 16; j++) prog[j] = 8'($urandom);
  endtask

  typedef struct {
    int n; int last; int budget; bit fixed; bit gaps; bit poke;
    int x_wr; bit x_err; int x_cyc; int xs_wr; bit xs_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{8,  7,  5, 1, 0, 0, 2, 0, 5, 2, 0};
    vecs[1] = '{8,  5,  5, 1, 0, 0, 1, 1, 0, 1, 1};
    vecs[2] = '{4,  3,  0, 0, 0, 0, 1, 0, 0, 1, 0};
    vecs[3] = '{12, 11, 3, 0, 0, 0, 3, 0, 3, 2, 1};
    vecs[4] = '{4,  0,  2, 0, 0, 0, 0, 1, 0, 0, 1};
    vecs[5] = '{16, 15, 7, 0, 1, 0, 4, 0, 7, 2, 1};
    vecs[6] = '{8,  7,  5, 1, 0, 1, 2, 0, 5, 2, 0};

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      if (vecs[v].fixed) load_fixed(); else load_random();
      do_run(vecs[v].n, vecs[v].last, vecs[v].budget, vecs[v].gaps, vecs[v].poke, 0);
      check($sformatf("vec%0d.writes", v),   wr_main.size(),   vecs[v].x_wr);
      check($sformatf("vec%0d.error", v),    32'(error),       32'(vecs[v].x_err));
      check($sformatf("vec%0d.clk_en", v),   en_main,          vecs[v].x_cyc);
      check($sformatf("vec%0d.s_writes", v), wr_small.size(),  vecs[v].xs_wr);
      check($sformatf("vec%0d.s_error", v),  32'(s_error),     32'(vecs[v].xs_err));
      verify_both(vecs[v].n, vecs[v].last, vecs[v].budget);
    end

    load_fixed();
    do_run(8, 7, 5, 0, 0, 3);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_abort");
    do_run(8, 7, 5, 0, 0, 0);
    verify_both(8, 7, 5);

    for (int r = 0; r < 10; r++) begin
      int n;
      int b;
      n = $urandom_range(1, 14);
      b = $urandom_range(0, 9);
      load_random();
      do_run(n, n - 1, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      verify_both(n, n - 1, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 Parameter IMEM_BYTES, default 1024, instruction-memory size in bytes (multiple of 4).
REQ-002 clock  in  1  system clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request to begin load+run; honoured only in IDLE, DONE, ERROR.
REQ-005 cycle_budget  in  16  number of CPU cycles to run, sampled when start is honoured.
REQ-006 byte_valid  in  1  program byte available.
REQ-007 byte_data  in  8  program byte, file order.
REQ-008 byte_last  in  1  marks final byte of program, qualified by byte_valid.
REQ-009 byte_ready  out  1  block accepts byte; transfer when byte_valid & byte_ready.
REQ-010 imem_we  out  1  instruction-memory word write strobe.
REQ-011 imem_addr  out  32  byte address of word written, multiple of 4.
REQ-012 imem_wdata  out  32  word written, little-endian.
REQ-013 cpu_reset  out  1  active-high reset held on risc_v_cpu.
REQ-014 cpu_clk_en  out  1  CPU clock enable; CPU state advances only when 1.
REQ-015 cycles_run  out  16  CPU cycles executed in current run.
REQ-016 busy / done / error  out  1 each  status flags.

Function
REQ-017 States IDLE, LOAD, COMMIT, RUN, DONE, ERROR, one-hot or encoded.
REQ-018 IDLE: byte_ready=0, cpu_reset=1, cpu_clk_en=0; start -> LOAD, clear word address, byte lane, cycles_run; latch cycle_budget.
REQ-019 LOAD: byte_ready=1; each accepted byte goes to lane 0,1,2,3 in turn (bits 7:0, 15:8, 23:16, 31:24).
REQ-020 Lane 3 accepted in cycle N -> imem_we=1 in cycle N+1 with imem_addr=word base, imem_wdata=assembled word; address then advances by 4.
REQ-021 byte_ready stays 1 during the write cycle; back-to-back bytes every cycle lose nothing.
REQ-022 byte_last on lane 3 -> COMMIT (cycle carrying final write, byte_ready=0), then RUN next cycle.
REQ-023 byte_last on lane 0-2 -> ERROR; partial word discarded, no write.
REQ-024 Byte accepted with word address = IMEM_BYTES -> ERROR, no write, address never wraps.
REQ-025 RUN: cpu_reset=0, cpu_clk_en=1; cycles_run increments each cycle; cycles_run = latched budget -> DONE, cpu_clk_en=0 that cycle.
REQ-026 Budget 0: COMMIT -> DONE directly, cpu_clk_en never 1.
REQ-027 DONE: done=1, cpu_reset=0, cpu_clk_en=0 (CPU frozen for inspection); start -> LOAD.
REQ-028 ERROR: error=1, cpu_reset=1, cpu_clk_en=0, sticky until start -> LOAD.
REQ-029 busy=1 in LOAD, COMMIT, RUN; start ignored there.
REQ-030 imem_we pulses exactly once per complete word, never outside LOAD/COMMIT.
REQ-031 cycles_run saturates at budget, no wrap.

Reset
REQ-032 reset low asynchronously forces IDLE: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, cpu_clk_en=0, cycles_run=0, busy=done=error=0.
REQ-033 Reset mid-LOAD or mid-RUN aborts; partial word lost; release resumes in IDLE only.

Structure
REQ-034 State encoding enum and lane count constant in shared package boot_pkg.
REQ-035 Sub-module byte_packer (lane counter + 32-bit assembly register) instantiated once; FSM and counters in top.

Verification
REQ-036 start, budget=5, bytes 13,05,A0,00,93,05,B0,00 last on 8th, valid every cycle -> writes 0x00A00513 @0, 0x00B00593 @4; exactly 5 cpu_clk_en cycles; done=1, cycles_run=5.
REQ-037 byte_last on 6th byte -> one write @0, error=1, cpu_reset=1, no cpu_clk_en.
REQ-038 IMEM_BYTES=8, 12 bytes -> writes @0,@4 only, error on 9th byte.
REQ-039 budget=0, 4 bytes -> one write, done without cpu_clk_en.
REQ-040 reset low during RUN cycle 3 -> all outputs at reset values immediately; subsequent start reloads from address 0.
REQ-041 start pulsed during LOAD and RUN -> ignored, write sequence and cycles_run unchanged.
